otn_rx_deframer: RTL and testbench

- Serial line receiver and ARQ acknowledge transmitter at the front of the receive path.
- Recovers bit timing from the incoming OTN-style serial stream, hunts for and tracks the frame alignment signal (FAS), and delivers aligned bytes with a frame-start flag to the demapper.
- Returns ACK/NACK codes on the serial ack line based on the demapper's CRC verdict when ARQ is enabled.

---
 rtl/otn_rx_deframer.sv | 149 ++++++++++++++
 tb/tb_otn_rx_deframer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/otn_rx_deframer.sv
// otn_rx_deframer: serial OTN receiver (bit recovery, FAS hunt/flywheel, byte delivery) and ARQ ack transmitter.
// Define RX_STATS_EN to add saturating frame, FAS-miss and NACK counters.
module otn_rx_deframer #(
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FRAME_BYTES  = 64,
   parameter logic [15:0] FAS_WORD     = 16'hF628,
   parameter int          FAS_MISS_MAX = 2,
   parameter logic [7:0]  ACK_CODE     = 8'hA5,
   parameter logic [7:0]  NACK_CODE    = 8'h5A
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_otn_tx_data,
   output logic       o_otn_rx_ack,
   input  logic       i_arq_en,
   input  logic       i_crc_err,
   input  logic       i_crc_err_valid,
   input  logic       i_tx_fifo_ready,
   output logic [7:0] o_frame_data,
   output logic       o_frame_data_valid,
   output logic       o_frame_data_fas,
   output logic       o_locked,
   output logic       o_drop
`ifdef RX_STATS_EN
   ,
   output logic [15:0] o_stat_frames,
   output logic [15:0] o_stat_fas_miss,
   output logic [15:0] o_stat_nack
`endif
);
   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(FRAME_BYTES);
   typedef enum logic {HUNT, SYNC} rx_st_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;
   rx_st_e         st_q;
   tx_st_e         tx_q;
   logic [1:0]     line_s_q, arq_s_q;
   logic           line_p_q, line_edge, smp, fas_hit, miss_out;
   logic [PW-1:0]  ph_q, tc_q;
   logic [14:0]    win_q;
   logic [15:0]    win_d;
   logic [2:0]     bc_q, tb_q;
   logic [IW-1:0]  idx_q;
   logic [7:0]     miss_q, dat_q, pb_q, sh_q, pc_q, code, tx_code;
   logic           v_q, fas_q, pend_q, ack_q, pv_q, stb, tx_go, tx_last;
   assign line_edge = line_s_q[1] ^ line_p_q;
   assign smp       = !line_edge && ph_q == PW'(CLKS_PER_BIT / 2);
   assign win_d     = {win_q, line_s_q[1]};
   assign fas_hit   = win_d == FAS_WORD;
   assign miss_out  = miss_q + 8'd1 >= 8'(FAS_MISS_MAX);
   assign stb       = i_crc_err_valid && arq_s_q[1];
   assign code      = i_crc_err ? NACK_CODE : ACK_CODE;
   assign tx_go     = tx_q == TX_IDLE && (stb || (pv_q && arq_s_q[1]));
   assign tx_code   = stb ? code : pc_q;
   assign tx_last   = tc_q == PW'(CLKS_PER_BIT - 1);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         line_s_q <= '0; arq_s_q <= '0; line_p_q <= 1'b0; ph_q <= '0; win_q <= '0;
         st_q <= HUNT; bc_q <= '0; idx_q <= '0; miss_q <= '0;
         v_q <= 1'b0; fas_q <= 1'b0; pend_q <= 1'b0; dat_q <= '0; pb_q <= '0;
      end else begin
         line_s_q <= {line_s_q[0], i_otn_tx_data};
         arq_s_q  <= {arq_s_q[0], i_arq_en};
         line_p_q <= line_s_q[1];
         ph_q     <= (line_edge || ph_q == PW'(CLKS_PER_BIT - 1)) ? '0 : ph_q + PW'(1);
         v_q      <= pend_q;
         fas_q    <= 1'b0;
         pend_q   <= 1'b0;
         if (pend_q) dat_q <= pb_q;
         if (smp) begin
            win_q <= win_d[14:0];
            if (st_q == HUNT) begin
               if (fas_hit) begin
                  st_q <= SYNC; idx_q <= IW'(2); bc_q <= '0; miss_q <= '0;
                  v_q <= 1'b1; fas_q <= 1'b1; dat_q <= win_d[15:8]; pend_q <= 1'b1; pb_q <= win_d[7:0];
               end
            end else begin
               bc_q <= bc_q + 3'd1;
               if (bc_q == 3'd7) begin
                  idx_q <= idx_q == IW'(FRAME_BYTES - 1) ? '0 : idx_q + IW'(1);
                  // byte 0 waits in the window until byte 1 completes the FAS check
                  if (idx_q == IW'(1)) begin
                     if (fas_hit || !miss_out) begin
                        miss_q <= fas_hit ? '0 : miss_q + 8'd1;
                        v_q <= 1'b1; fas_q <= fas_hit; dat_q <= win_d[15:8]; pend_q <= 1'b1; pb_q <= win_d[7:0];
                     end else begin
                        st_q <= HUNT; miss_q <= '0;
                     end
                  end else if (idx_q != '0) begin
                     v_q <= 1'b1; dat_q <= win_d[7:0];
                  end
               end
            end
         end
      end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         tx_q <= TX_IDLE; tc_q <= '0; tb_q <= '0; sh_q <= '0; ack_q <= 1'b1; pv_q <= 1'b0; pc_q <= '0;
      end else begin
         if (!arq_s_q[1]) pv_q <= 1'b0;
         if (tx_q == TX_IDLE) begin
            tc_q <= '0;
            if (tx_go) begin
               tx_q <= TX_START; sh_q <= tx_code; ack_q <= 1'b0; pv_q <= 1'b0;
            end
         end else begin
            if (stb) begin
               pv_q <= 1'b1; pc_q <= code;
            end
            tc_q <= tx_last ? '0 : tc_q + PW'(1);
            if (tx_last)
               case (tx_q)
                  TX_START: begin tx_q <= TX_DATA; tb_q <= '0; ack_q <= sh_q[0]; end
                  TX_DATA:
                     if (tb_q == 3'd7) begin
                        tx_q <= TX_STOP; ack_q <= 1'b1;
                     end else begin
                        tb_q <= tb_q + 3'd1; sh_q <= {1'b0, sh_q[7:1]}; ack_q <= sh_q[1];
                     end
                  default: tx_q <= TX_IDLE;
               endcase
         end
      end
`ifdef RX_STATS_EN
   logic        chk1, frame_inc, miss_inc, nack_inc;
   logic [15:0] frames_q, fmiss_q, nack_q;
   assign chk1      = smp && st_q == SYNC && bc_q == 3'd7 && idx_q == IW'(1);
   assign frame_inc = smp && fas_hit && (st_q == HUNT || chk1);
   assign miss_inc  = chk1 && !fas_hit;
   assign nack_inc  = tx_go && tx_code == NACK_CODE;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         frames_q <= '0; fmiss_q <= '0; nack_q <= '0;
      end else begin
         if (frame_inc && frames_q != '1) frames_q <= frames_q + 16'd1;
         if (miss_inc && fmiss_q != '1) fmiss_q <= fmiss_q + 16'd1;
         if (nack_inc && nack_q != '1) nack_q <= nack_q + 16'd1;
      end
   assign o_stat_frames   = frames_q;
   assign o_stat_fas_miss = fmiss_q;
   assign o_stat_nack     = nack_q;
`endif
   assign o_otn_rx_ack       = ack_q;
   assign o_frame_data       = dat_q;
   assign o_frame_data_valid = v_q & i_tx_fifo_ready;
   assign o_frame_data_fas   = fas_q & i_tx_fifo_ready;
   assign o_drop             = v_q & ~i_tx_fifo_ready;
   assign o_locked           = st_q == SYNC;
endmodule

// File: tb/tb_otn_rx_deframer.sv
// tb_otn_rx_deframer: scoreboard bench for otn_rx_deframer at CLKS_PER_BIT=4, FRAME_BYTES=8.
module tb_otn_rx_deframer;
   logic clk = 0, rst_n = 0, line = 1, arq = 0, crc_err = 0, crc_v = 0, ready = 1;
   logic ack, dv, dfas, locked, drop;
   logic [7:0] data;
   logic [8:0] sb[$];
   logic [8:0] e;
   logic [19:0] pre;
   logic [51:0] s;
   logic [7:0] bv;
   logic clean;
   int n_cmp = 0, n_err = 0, drops = 0;
`ifdef RX_STATS_EN
   logic [15:0] st_f, st_m, st_n;
`endif
   always #5 clk = ~clk;
   otn_rx_deframer #(.CLKS_PER_BIT(4), .FRAME_BYTES(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_otn_tx_data(line), .o_otn_rx_ack(ack),
      .i_arq_en(arq), .i_crc_err(crc_err), .i_crc_err_valid(crc_v), .i_tx_fifo_ready(ready),
      .o_frame_data(data), .o_frame_data_valid(dv), .o_frame_data_fas(dfas),
      .o_locked(locked), .o_drop(drop)
`ifdef RX_STATS_EN
      , .o_stat_frames(st_f), .o_stat_fas_miss(st_m), .o_stat_nack(st_n)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (drop) drops++;
      if (dv) begin
         if (sb.size() == 0) chk("sb_unexpected_byte", 32'(sb.size()), 1);
         else begin
            e = sb.pop_front();
            chk("sb_byte", {dfas, data}, e);
            if (dfas) chk("lock_with_fas", locked, 1);
         end
      end
   end
   task automatic push(input logic [7:0] b, input logic f);
      sb.push_back({f, b});
   endtask
   task automatic send_bit(input logic b);
      line = b;
      repeat (4) @(negedge clk);
   endtask
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask
   task automatic strobe(input logic err);
      crc_err = err; crc_v = 1;
      @(negedge clk);
      crc_v = 0;
   endtask
   task automatic check_code(input logic [7:0] code, input string tag);
      logic [9:0] bits;
      bits = {1'b1, code, 1'b0};
      for (int n = 0; n < 10; n++) begin
         if (n > 0) repeat (4) @(negedge clk);
         chk($sformatf("%s_bit%0d", tag, n), ack, bits[n]);
      end
   endtask
   task automatic wait_start(input string tag);
      int t;
      t = 0;
      while (ack !== 1'b0 && t < 64) begin @(negedge clk); t++; end
      chk({tag, "_start_seen"}, ack, 0);
      @(negedge clk);
   endtask
   task automatic quiet(input string tag, input int n);
      logic seen;
      seen = 0;
      repeat (n) begin @(negedge clk); if (!ack) seen = 1; end
      chk(tag, seen, 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 1);
      chk("rst_valid", dv, 0);
      chk("rst_locked", locked, 0);
      chk("rst_drop", drop, 0);
      chk("rst_data", {dfas, data}, 0);
      rst_n = 1; arq = 1;
      repeat (4) @(negedge clk);
      strobe(0); @(negedge clk); check_code(8'hA5, "ack_a5");
      repeat (4) @(negedge clk);
      strobe(1); @(negedge clk); check_code(8'h5A, "nack_5a");
      repeat (4) @(negedge clk);
      strobe(0); strobe(1); strobe(0);
      check_code(8'hA5, "inflight");
      wait_start("pending");
      check_code(8'hA5, "last_wins");
      quiet("no_third_code", 60);
      strobe(0); strobe(1); arq = 0;
      check_code(8'hA5, "arq_drop_cur");
      quiet("arq_drop_pend", 60);
      strobe(1);
      quiet("arq_off", 60);
      do begin
         pre = 20'($urandom);
         s = {16'hFFFF, pre, 16'hF628};
         clean = 1;
         for (int j = 0; j < 36; j++) if (s[51 - j -: 16] == 16'hF628) clean = 0;
      end while (!clean);
      push(8'hF6, 1); push(8'h28, 0);
      for (int i = 1; i <= 6; i++) push(8'(i), 0);
      push(8'hF6, 0); push(8'h29, 0);
      for (int i = 1; i <= 6; i++) push(8'(8'h10 + i), 0);
      for (int i = 19; i >= 0; i--) send_bit(pre[i]);
      send_byte(8'hF6); send_byte(8'h28);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      send_byte(8'hF6); send_byte(8'h29);
      for (int i = 1; i <= 6; i++) send_byte(8'(8'h10 + i));
      chk("lock_flywheel", locked, 1);
      send_byte(8'hF6); send_byte(8'h2A);
      for (int i = 1; i <= 6; i++) send_byte(8'(8'h20 + i));
      repeat (8) send_bit(1);
      chk("lock_lost", locked, 0);
      chk("sb_drained_1", 32'(sb.size()), 0);
      arq = 1;
      push(8'hF6, 1); push(8'h28, 0); push(8'h31, 0);
      for (int i = 3; i <= 6; i++) push(8'(8'h30 + i), 0);
      send_byte(8'hF6); send_byte(8'h28); send_byte(8'h31);
      bv = 8'h32;
      for (int i = 7; i >= 0; i--) begin if (i == 4) ready = 0; send_bit(bv[i]); end
      bv = 8'h33;
      for (int i = 7; i >= 0; i--) begin if (i == 3) ready = 1; send_bit(bv[i]); end
      for (int i = 4; i <= 6; i++) send_byte(8'(8'h30 + i));
      send_byte(8'hF6);
      chk("sb_drained_2", 32'(sb.size()), 0);
      chk("drop_once", drops, 1);
      send_bit(0); send_bit(0); send_bit(1); send_bit(0);
      strobe(0); @(negedge clk);
      chk("ack_busy", ack, 0);
      chk("lock_pre_rst", locked, 1);
      rst_n = 0;
      #1;
      chk("arst_ack", ack, 1);
      chk("arst_locked", locked, 0);
      chk("arst_valid", dv, 0);
      chk("arst_drop", drop, 0);
      chk("arst_data", {dfas, data}, 0);
      repeat (2) @(negedge clk);
      line = 1; rst_n = 1;
      repeat (4) send_bit(1);
      push(8'hF6, 1); push(8'h28, 0);
      for (int i = 1; i <= 6; i++) push(8'(8'h40 + i), 0);
      send_byte(8'hF6); send_byte(8'h28);
      for (int i = 1; i <= 6; i++) send_byte(8'(8'h40 + i));
      repeat (12) @(negedge clk);
      chk("sb_drained_3", 32'(sb.size()), 0);
      chk("relock", locked, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
